// File: rtl/midi_note_decoder.sv
// midi_note_decoder: turns the received MIDI byte stream into note events
// (note_num, note_vel and one-ce-cycle note_on / note_off strobes) for the
// voice allocator. Decodes one channel, skips real-time, SysEx,
// system-common and non-note channel messages.
//
// Build option: define MIDI_RUNNING_STATUS_EN so that bare data pairs repeat
// the last channel message. Without it, every message needs its own status
// byte.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no message type known, data bytes discarded
// D1     | waiting for first data byte (key / program / etc.)
// D2     | waiting for second data byte (velocity / value)
// SYSEX  | inside a system-exclusive dump, data bytes discarded

module midi_note_decoder #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic       note_on,
    output logic       note_off
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_D1    = 2'd1;
    localparam logic [1:0] ST_D2    = 2'd2;
    localparam logic [1:0] ST_SYSEX = 2'd3;

    // SKIP2 is the all-zero code so a cleared running status is harmless.
    localparam logic [1:0] RS_SKIP2    = 2'd0;
    localparam logic [1:0] RS_SKIP1    = 2'd1;
    localparam logic [1:0] RS_NOTE_OFF = 2'd2;
    localparam logic [1:0] RS_NOTE_ON  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] rs_type_q, rs_type_d;
    logic [6:0] key_q, key_d;
    logic [6:0] note_num_q, note_num_d;
    logic [6:0] note_vel_q, note_vel_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;

    logic       is_status;
    logic       is_realtime;
    logic [1:0] status_type;
    logic [1:0] done_state;
    logic [1:0] done_rs_type;

    assign is_status   = rx_data[7];
    assign is_realtime = (rx_data >= 8'hF8);

    // Classify a channel-voice status byte into a running-status type.
    always_comb begin
        status_type = RS_SKIP2;
        if (rx_data[6:4] == 3'b000 && rx_data[3:0] == CHANNEL) begin
            status_type = RS_NOTE_OFF;
        end else if (rx_data[6:4] == 3'b001 && rx_data[3:0] == CHANNEL) begin
            status_type = RS_NOTE_ON;
        end else if (rx_data[6:4] == 3'b100 || rx_data[6:4] == 3'b101) begin
            status_type = RS_SKIP1;
        end
    end

    // Where a completed message leaves the parser.
`ifdef MIDI_RUNNING_STATUS_EN
    assign done_state   = ST_D1;
    assign done_rs_type = rs_type_q;
`else
    assign done_state   = ST_IDLE;
    assign done_rs_type = RS_SKIP2;
`endif

    // Byte parser and note event generation; everything holds while ce=0.
    always_comb begin
        state_d    = state_q;
        rs_type_d  = rs_type_q;
        key_d      = key_q;
        note_num_d = note_num_q;
        note_vel_d = note_vel_q;
        note_on_d  = note_on_q;
        note_off_d = note_off_q;

        if (ce) begin
            // Strobes last exactly one ce-cycle unless re-asserted below.
            note_on_d  = 1'b0;
            note_off_d = 1'b0;

            if (rx_valid && !is_realtime) begin
                if (is_status) begin
                    // Any status byte aborts a partial message first.
                    if (rx_data == 8'hF0) begin
                        state_d   = ST_SYSEX;
                        rs_type_d = RS_SKIP2;
                    end else if (rx_data[7:4] == 4'hF) begin
                        state_d   = ST_IDLE;
                        rs_type_d = RS_SKIP2;
                    end else begin
                        state_d   = ST_D1;
                        rs_type_d = status_type;
                    end
                end else begin
                    case (state_q)
                        ST_D1: begin
                            key_d = rx_data[6:0];
                            if (rs_type_q == RS_SKIP1) begin
                                state_d   = done_state;
                                rs_type_d = done_rs_type;
                            end else begin
                                state_d = ST_D2;
                            end
                        end
                        ST_D2: begin
                            state_d   = done_state;
                            rs_type_d = done_rs_type;
                            if (rs_type_q == RS_NOTE_ON || rs_type_q == RS_NOTE_OFF) begin
                                note_num_d = key_q;
                                note_vel_d = rx_data[6:0];
                                if (rs_type_q == RS_NOTE_ON && rx_data[6:0] != 7'd0) begin
                                    note_on_d = 1'b1;
                                end else begin
                                    note_off_d = 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rs_type_q  <= RS_SKIP2;
            key_q      <= 7'd0;
            note_num_q <= 7'd0;
            note_vel_q <= 7'd0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_type_q  <= rs_type_d;
            key_q      <= key_d;
            note_num_q <= note_num_d;
            note_vel_q <= note_vel_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
        end
    end

    assign note_num = note_num_q;
    assign note_vel = note_vel_q;
    assign note_on  = note_on_q;
    assign note_off = note_off_q;

endmodule
